// File: rtl/mux4way_rr.sv
// mux4way_rr -- 4-to-1 valid/ready merge with a registered output channel.
//
// Four upstream channels compete for one output register. The channel that
// wins is granted round-robin, starting the search at pointer ptr, and ptr
// moves to the channel after the winner on every transfer. The output is
// tagged with z = source channel - 1, which matches the select encoding of
// dmux4way, so replies can be routed back.
//
// Build option:
//   MUX4WAY_FIXED_PRIO_EN  defined   -> no pointer, fixed priority ch1>ch2>ch3>ch4
//                          undefined -> round-robin (default)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in1..in4 / valid1..valid4  upstream data and valid
//   ready1..ready4             upstream ready (granted channel, slot free)
//   out, z, out_valid          registered merged word, source tag, valid
//   out_ready                  downstream accept
module mux4way_rr #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] in4,
   input  logic             valid1,
   input  logic             valid2,
   input  logic             valid3,
   input  logic             valid4,
   output logic             ready1,
   output logic             ready2,
   output logic             ready3,
   output logic             ready4,
   output logic [WIDTH-1:0] out,
   output logic [1:0]       z,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [3:0]       w_valid;
   logic [3:0]       w_grant;
   logic [1:0]       w_gidx;
   logic             w_found;
   logic             w_free;
   logic             w_xfer;
   logic [1:0]       w_ptr;
   logic [WIDTH-1:0] w_din;

   logic [WIDTH-1:0] r_out;
   logic [1:0]       r_z;
   logic             r_out_valid;

   assign w_valid = {valid4, valid3, valid2, valid1};
   assign w_free  = ~r_out_valid | out_ready;
   // A grant only implies a valid, so any grant with a free slot is a transfer.
   assign w_xfer  = w_found & w_free;

`ifdef MUX4WAY_FIXED_PRIO_EN
   // Search always starts at ch1.
   assign w_ptr = 2'b00;
`else
   logic [1:0] r_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_ptr <= 2'b00;
      else if (w_xfer) r_ptr <= w_gidx + 2'd1;
   end

   assign w_ptr = r_ptr;
`endif

   // Walk the channels in priority order ptr, ptr+1, ... (mod 4) and pick the
   // first one that is valid.
   always_comb begin
      logic [1:0] idx;
      idx     = 2'b00;
      w_gidx  = 2'b00;
      w_found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = w_ptr + 2'(i);
         if (!w_found && w_valid[idx]) begin
            w_found = 1'b1;
            w_gidx  = idx;
         end
      end
      w_grant = w_found ? (4'b0001 << w_gidx) : 4'b0000;
   end

   always_comb begin
      case (w_gidx)
         2'd0:    w_din = in1;
         2'd1:    w_din = in2;
         2'd2:    w_din = in3;
         default: w_din = in4;
      endcase
   end

   // rst_n gates the readys so nothing is handshaken while reset is held.
   assign ready1 = w_grant[0] & w_free & rst_n;
   assign ready2 = w_grant[1] & w_free & rst_n;
   assign ready3 = w_grant[2] & w_free & rst_n;
   assign ready4 = w_grant[3] & w_free & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out       <= '0;
         r_z         <= 2'b00;
         r_out_valid <= 1'b0;
      end else if (w_xfer) begin
         r_out       <= w_din;
         r_z         <= w_gidx;
         r_out_valid <= 1'b1;
      end else if (out_ready) begin
         // Drained with nothing to refill: data and tag keep their last values.
         r_out_valid <= 1'b0;
      end
   end

   assign out       = r_out;
   assign z         = r_z;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux4way_rr.sv
// Scoreboard bench for mux4way_rr (default round-robin build).
// Stimulus pushes each expected {z,out} word when the handshake is issued;
// a monitor pops and compares whenever the output is consumed.
module tb_mux4way_rr;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] in1 = 16'h0001, in2 = 16'h0002, in3 = 16'h0003, in4 = 16'h0004;
   logic        valid1 = 0, valid2 = 0, valid3 = 0, valid4 = 0;
   logic        ready1, ready2, ready3, ready4;
   logic [15:0] out;
   logic [1:0]  z;
   logic        out_valid;
   logic        out_ready = 1'b0;

   logic [17:0] sb[$];
   int          n_total = 0;
   int          n_pass  = 0;

   mux4way_rr #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in1(in1), .in2(in2), .in3(in3), .in4(in4),
      .valid1(valid1), .valid2(valid2), .valid3(valid3), .valid4(valid4),
      .ready1(ready1), .ready2(ready2), .ready3(ready3), .ready4(ready4),
      .out(out), .z(z), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitor: every consumed output word must match the oldest expected one.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL mon_unexpected: got z=%0d out=%h expected no word at %0t", z, out, $time);
         end else begin
            logic [17:0] e;
            e = sb.pop_front();
            chk("mon_word", {14'd0, z, out}, {14'd0, e});
         end
      end
   end

   // One cycle: drive at #1 after posedge, check readys at negedge, push the
   // expected word if a transfer is issued, then move past the next posedge.
   task automatic cyc(input logic [3:0] v, input logic ordy, input logic [3:0] exp_rdy,
                      input logic push, input logic [1:0] ez, input logic [15:0] ed);
      {valid4, valid3, valid2, valid1} = v;
      out_ready = ordy;
      @(negedge clk);
      chk("ready", {28'd0, ready4, ready3, ready2, ready1}, {28'd0, exp_rdy});
      if (push) sb.push_back({ez, ed});
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state();
      chk("rst_out",   {16'd0, out}, 32'd0);
      chk("rst_z",     {30'd0, z}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_ready", {28'd0, ready4, ready3, ready2, ready1}, 32'd0);
   endtask

   initial begin
      // Power-on reset with all channels requesting: readys must stay 0.
      {valid4, valid3, valid2, valid1} = 4'b1111;
      out_ready = 1'b1;
      #1;
      chk_reset_state();
      @(posedge clk); #1;
      rst_n = 1'b1;
      {valid4, valid3, valid2, valid1} = 4'b0000;

      // Single channel: ch3 only, then ch4 must win over ch1.
      in3 = 16'b1111000011110000;
      cyc(4'b0100, 1'b1, 4'b0100, 1'b1, 2'b10, 16'hF0F0);
      chk("single_out", {16'd0, out}, 32'h0000F0F0);
      chk("single_z",   {30'd0, z}, 32'd2);
      cyc(4'b1001, 1'b1, 4'b1000, 1'b1, 2'b11, 16'h0004);
      in3 = 16'h0003;

      // Round robin from ptr=0: ch1..ch4 twice.
      for (int i = 0; i < 8; i++) begin
         cyc(4'b1111, 1'b1, 4'b0001 << (i % 4), 1'b1, 2'(i % 4), 16'(i % 4 + 1));
         chk("rr_valid", {31'd0, out_valid}, 32'd1);
      end

      // Backpressure: ch4 word held for 5 cycles, no readys.
      for (int i = 0; i < 5; i++) begin
         cyc(4'b1111, 1'b0, 4'b0000, 1'b0, 2'b00, 16'h0000);
         chk("stall_out", {16'd0, out}, 32'h00000004);
         chk("stall_z",   {30'd0, z}, 32'd3);
      end
      // Release: held word consumed and ch1 (ptr=0) loaded in the same cycle.
      cyc(4'b1111, 1'b1, 4'b0001, 1'b1, 2'b00, 16'h0001);
      chk("release_valid", {31'd0, out_valid}, 32'd1);

      // Sparse wrap-around: get ptr to 3 via ch3, then ch1/ch3 alternate.
      cyc(4'b0100, 1'b1, 4'b0100, 1'b1, 2'b10, 16'h0003);
      cyc(4'b0101, 1'b1, 4'b0001, 1'b1, 2'b00, 16'h0001);
      cyc(4'b0101, 1'b1, 4'b0100, 1'b1, 2'b10, 16'h0003);
      cyc(4'b0101, 1'b1, 4'b0001, 1'b1, 2'b00, 16'h0001);

      // Drain without refill: valid drops, data and tag hold.
      cyc(4'b0000, 1'b1, 4'b0000, 1'b0, 2'b00, 16'h0000);
      chk("drain_valid", {31'd0, out_valid}, 32'd0);
      chk("drain_out",   {16'd0, out}, 32'h00000001);
      chk("drain_z",     {30'd0, z}, 32'd0);

      // Reset mid-stream: ch2 (ptr=1) loaded, held, then discarded by reset.
      cyc(4'b1111, 1'b1, 4'b0010, 1'b1, 2'b01, 16'h0002);
      out_ready = 1'b0;
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      out_ready = 1'b1;
      #1;
      chk_reset_state();
      sb.delete();
      @(posedge clk); #1;
      chk_reset_state();
      rst_n = 1'b1;
      // Pointer back to 0: ch1 wins first.
      cyc(4'b1111, 1'b1, 4'b0001, 1'b1, 2'b00, 16'h0001);
      cyc(4'b0000, 1'b1, 4'b0000, 1'b0, 2'b00, 16'h0000);
      cyc(4'b0000, 1'b1, 4'b0000, 1'b0, 2'b00, 16'h0000);
      chk("sb_empty", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
